// File: rtl/icache_axi_rd_bridge_pkg.sv
// Shared AXI4 read-channel codes and one-hot state encodings for the I-cache refill bridge.
// Also holds the R-beat word-select and error helpers used by the bridge.
package icache_axi_rd_bridge_pkg;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B     = 3'b010;
    localparam logic [2:0] AXI_PROT_INSN   = 3'b100;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [7:0] AXI_LEN_SINGLE  = 8'd0;

    typedef enum logic [4:0] {
        ST_IDLE = 5'b00001,
        ST_AR   = 5'b00010,
        ST_R    = 5'b00100,
        ST_RESP = 5'b01000,
        ST_HOLD = 5'b10000
    } bridge_state_e;

    function automatic logic [31:0] sel_word(input logic [63:0] data, input logic hi);
        logic [31:0] word;
        if (hi) begin
            word = data[63:32];
        end else begin
            word = data[31:0];
        end
        return word;
    endfunction

    // A mismatched RID means the beat is not ours; report it like a bus error.
    function automatic logic rd_is_err(input logic [1:0] resp, input logic [3:0] rid,
                                       input logic [3:0] exp_id);
        return (resp != AXI_RESP_OKAY) || (rid != exp_id);
    endfunction

endpackage

// File: rtl/icache_axi_rd_bridge.sv
// I-cache refill responder: turns a level-held miss request into one single-beat AXI4 read
// and returns the addressed 32-bit instruction word with a one-cycle cache_in_ok pulse.
module icache_axi_rd_bridge
    import icache_axi_rd_bridge_pkg::*;
#(
    parameter logic [3:0] AXI_ID = 4'd0,
    parameter int         ADDR_W = 64,
    parameter int         DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cache_read_ena,
    input  logic [ADDR_W-1:0] cache_addr,
    output logic [31:0]       cache_or_data,
    output logic              cache_in_ok,
    output logic              cache_rd_err,
    output logic              axi_ar_valid,
    input  logic              axi_ar_ready,
    output logic [ADDR_W-1:0] axi_ar_addr,
    output logic [3:0]        axi_ar_id,
    output logic [7:0]        axi_ar_len,
    output logic [2:0]        axi_ar_size,
    output logic [1:0]        axi_ar_burst,
    output logic [2:0]        axi_ar_prot,
    input  logic              axi_r_valid,
    output logic              axi_r_ready,
    input  logic [DATA_W-1:0] axi_r_data,
    input  logic [1:0]        axi_r_resp,
    input  logic              axi_r_last,
    input  logic [3:0]        axi_r_id
);

    bridge_state_e     state_r;
    bridge_state_e     state_s;
    logic              deliver_s;
    logic              rd_err_s;
    logic              word_sel_r;
    logic              withdrawn_r;
    logic              axi_ar_valid_r;
    logic              axi_r_ready_r;
    logic              cache_in_ok_r;
    logic              cache_rd_err_r;
    logic [31:0]       cache_or_data_r;
    logic [ADDR_W-1:0] axi_ar_addr_r;
    logic              unused_s;

    // Single-beat reads: RLAST carries no extra information, and the low address bits are dropped.
    assign unused_s = ^{axi_r_last, cache_addr[1:0]};

    assign rd_err_s  = rd_is_err(axi_r_resp, axi_r_id, AXI_ID);
    assign deliver_s = cache_read_ena && !withdrawn_r;

    // Next-state logic for the refill FSM.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cache_read_ena) begin
                    state_s = ST_AR;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_AR: begin
                if (axi_ar_ready) begin
                    state_s = ST_R;
                end else begin
                    state_s = ST_AR;
                end
            end
            ST_R: begin
                if (axi_r_valid && deliver_s) begin
                    state_s = ST_RESP;
                end else if (axi_r_valid) begin
                    state_s = ST_HOLD;
                end else begin
                    state_s = ST_R;
                end
            end
            ST_RESP: state_s = ST_HOLD;
            ST_HOLD: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register and handshake/response outputs, all registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            axi_ar_valid_r <= 1'b0;
            axi_r_ready_r  <= 1'b0;
            cache_in_ok_r  <= 1'b0;
            cache_rd_err_r <= 1'b0;
        end else begin
            state_r        <= state_s;
            axi_ar_valid_r <= (state_s == ST_AR);
            axi_r_ready_r  <= (state_s == ST_R);
            cache_in_ok_r  <= (state_s == ST_RESP);
            cache_rd_err_r <= (state_s == ST_RESP) && rd_err_s;
        end
    end

    // Request capture, withdrawal tracking and returned-word capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            axi_ar_addr_r   <= {ADDR_W{1'b0}};
            word_sel_r      <= 1'b0;
            withdrawn_r     <= 1'b0;
            cache_or_data_r <= 32'd0;
        end else begin
            if ((state_r == ST_IDLE) && cache_read_ena) begin
                axi_ar_addr_r <= {cache_addr[ADDR_W-1:2], 2'b00};
                word_sel_r    <= cache_addr[2];
                withdrawn_r   <= 1'b0;
            end else if (((state_r == ST_AR) || (state_r == ST_R)) && !cache_read_ena) begin
                withdrawn_r   <= 1'b1;
            end
            // A withdrawn request still drains its beat but leaves the last delivered word in place.
            if ((state_r == ST_R) && axi_r_valid && deliver_s) begin
                cache_or_data_r <= sel_word(axi_r_data, word_sel_r);
            end
        end
    end

    assign axi_ar_valid  = axi_ar_valid_r;
    assign axi_r_ready   = axi_r_ready_r;
    assign cache_in_ok   = cache_in_ok_r;
    assign cache_rd_err  = cache_rd_err_r;
    assign cache_or_data = cache_or_data_r;
    assign axi_ar_addr   = axi_ar_addr_r;
    assign axi_ar_id     = AXI_ID;
    assign axi_ar_len    = AXI_LEN_SINGLE;
    assign axi_ar_size   = AXI_SIZE_4B;
    assign axi_ar_burst  = AXI_BURST_INCR;
    assign axi_ar_prot   = AXI_PROT_INSN;

endmodule
